// File: rtl/reg_pipe_pkg.sv
// ---------------------------------------------------------------------------
// reg_pipe_pkg
//   Shared types and helpers for the elastic pipeline register.
//   - stage_st_t : per-stage occupancy state (empty / main full / main+skid full)
//   - occ_w()    : width of an occupancy counter able to hold 0..2*depth
// ---------------------------------------------------------------------------
package reg_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_st_t;

  // Each stage holds at most two beats, so the whole chain holds 2*depth.
  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// reg_pipe_skid_stage
//   One elastic stage with a 2-entry skid buffer (main + skid register).
//   in_ready is a function of registered state only, so there is no
//   combinational path from out_ready to in_ready; the skid entry catches
//   the beat that arrives in the cycle the downstream side stalls.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous flush (empties stage, zeroes data)
//   hold       synchronous stall (no handshakes, no state change)
//   in_valid   upstream beat present
//   in_data    upstream payload [N-1:0]
//   in_ready   stage can accept (not FULL, not held, not in reset)
//   out_valid  stage presents a beat (not EMPTY, not held)
//   out_data   payload of the main register [N-1:0]
//   out_ready  downstream accepts
// ---------------------------------------------------------------------------
module reg_pipe_skid_stage
  import reg_pipe_pkg::*;
#(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         hold,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready
);

  stage_st_t    state_reg, state_next;
  logic [N-1:0] main_reg, main_next;
  logic [N-1:0] skid_reg, skid_next;
  logic         in_fire;
  logic         out_fire;

  // Gating with hold on both sides keeps neighbouring stages consistent:
  // no handshake can complete anywhere while the pipe is stalled.
  assign in_ready  = !rst && !hold && (state_reg != ST_FULL);
  assign out_valid = !hold && (state_reg != ST_EMPTY);
  assign out_data  = main_reg;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (clear) begin
      // Flush wins over any handshake seen this cycle.
      state_next = ST_EMPTY;
      main_next  = '0;
      skid_next  = '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            state_next = ST_BUSY;
            main_next  = in_data;
          end
        end
        ST_BUSY: begin
          if (in_fire && !out_fire) begin
            state_next = ST_FULL;
            skid_next  = in_data;
          end else if (!in_fire && out_fire) begin
            state_next = ST_EMPTY;
          end else if (in_fire && out_fire) begin
            main_next = in_data;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            state_next = ST_BUSY;
            main_next  = skid_reg;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_pipe_elastic.sv
// ---------------------------------------------------------------------------
// reg_pipe_elastic
//   DEPTH chained elastic stages of N-bit data with valid/ready handshake,
//   global hold (stall) and clear (flush). Zero-backpressure latency is
//   DEPTH cycles; sustained throughput is one beat per cycle; up to 2*DEPTH
//   beats are absorbed while out_ready is low.
//
// Configuration
//   REG_PIPE_OCC_EN  when defined, adds the occ output: a registered count
//                    of occupied entries (0..2*DEPTH).
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous flush of every stage
//   hold       synchronous stall of every stage
//   in_valid   upstream beat present
//   in_data    upstream payload [N-1:0]
//   in_ready   stage 0 can accept
//   out_valid  last stage presents a beat
//   out_data   last-stage payload [N-1:0]
//   out_ready  downstream accepts
//   occ        occupied entries (REG_PIPE_OCC_EN only)
// ---------------------------------------------------------------------------
module reg_pipe_elastic
  import reg_pipe_pkg::*;
#(
  parameter int N     = 1,
  parameter int DEPTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       hold,
  input  logic                       in_valid,
  input  logic [N-1:0]               in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [N-1:0]               out_data,
  input  logic                       out_ready
`ifdef REG_PIPE_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0]    occ
`endif
);

  // Index k is the boundary in front of stage k; index DEPTH is the output.
  logic         valid_chain [DEPTH+1];
  logic         ready_chain [DEPTH+1];
  logic [N-1:0] data_chain  [DEPTH+1];

  assign valid_chain[0]     = in_valid;
  assign data_chain[0]      = in_data;
  assign in_ready           = ready_chain[0];
  assign ready_chain[DEPTH] = out_ready;
  assign out_valid          = valid_chain[DEPTH];
  assign out_data           = data_chain[DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      reg_pipe_skid_stage #(
        .N(N)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .hold     (hold),
        .in_valid (valid_chain[gi]),
        .in_data  (data_chain[gi]),
        .in_ready (ready_chain[gi]),
        .out_valid(valid_chain[gi+1]),
        .out_data (data_chain[gi+1]),
        .out_ready(ready_chain[gi+1])
      );
    end
  endgenerate

`ifdef REG_PIPE_OCC_EN
  localparam int OCC_W = occ_w(DEPTH);

  logic             pipe_in_fire;
  logic             pipe_out_fire;
  logic [OCC_W-1:0] occ_reg, occ_next;

  assign pipe_in_fire  = in_valid && in_ready;
  assign pipe_out_fire = out_valid && out_ready;
  assign occ           = occ_reg;

  always_comb begin
    occ_next = occ_reg;
    if (clear) begin
      occ_next = '0;
    end else if (pipe_in_fire && !pipe_out_fire) begin
      occ_next = occ_reg + OCC_W'(1);
    end else if (!pipe_in_fire && pipe_out_fire) begin
      occ_next = occ_reg - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end
`endif

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// ---------------------------------------------------------------------------
// tb_reg_pipe_elastic
//   dut_a: N=32, DEPTH=3 (latency, random backpressure, hold, clear, reset)
//   dut_b: N=32, DEPTH=2 (backpressure absorption, table driven)
// ---------------------------------------------------------------------------
module tb_reg_pipe_elastic;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic hold;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
`ifdef REG_PIPE_OCC_EN
  logic [reg_pipe_pkg::occ_w(3)-1:0] a_occ;
  logic [reg_pipe_pkg::occ_w(2)-1:0] b_occ;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  reg_pipe_elastic #(.N(32), .DEPTH(3)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .hold(hold),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready)
`ifdef REG_PIPE_OCC_EN
    , .occ(a_occ)
`endif
  );

  reg_pipe_elastic #(.N(32), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .hold(hold),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready)
`ifdef REG_PIPE_OCC_EN
    , .occ(b_occ)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for dut_a: push on input handshake, pop on output handshake.
  always @(negedge clk) begin
    if (rst || clear) begin
      sb.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got beat %08h, expected none", a_out_data);
        end else begin
          logic [31:0] exp_beat;
          exp_beat = sb.pop_front();
          if (a_out_data !== exp_beat) begin
            fails++;
            $display("FAIL sb_order: got %08h, expected %08h", a_out_data, exp_beat);
          end else begin
            $display("[TB] beat %08h delivered", a_out_data);
          end
        end
      end
      if (a_in_valid && a_in_ready) sb.push_back(a_in_data);
    end
  end

  typedef struct {
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [31:0] exp_out_data;
    int          exp_occ;
  } vec_t;

  vec_t tbl[11];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held_data;
    int          held_occ;

    // DEPTH=2 backpressure: 4 beats absorbed, then drained in order.
    tbl[0]  = '{1'b1, 32'hB1, 1'b0, 1'b1, 1'b0, 32'h0,  0};
    tbl[1]  = '{1'b1, 32'hB2, 1'b0, 1'b1, 1'b0, 32'h0,  1};
    tbl[2]  = '{1'b1, 32'hB3, 1'b0, 1'b1, 1'b1, 32'hB1, 2};
    tbl[3]  = '{1'b1, 32'hB4, 1'b0, 1'b1, 1'b1, 32'hB1, 3};
    tbl[4]  = '{1'b1, 32'hB5, 1'b0, 1'b0, 1'b1, 32'hB1, 4};
    tbl[5]  = '{1'b1, 32'hB5, 1'b0, 1'b0, 1'b1, 32'hB1, 4};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hB1, 4};
    tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hB2, 3};
    tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB3, 2};
    tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB4, 1};
    tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  0};

    rst = 1'b1; clear = 1'b0; hold = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data", a_out_data, 32'd0);
`ifdef REG_PIPE_OCC_EN
    check("rst_occ", 32'(a_occ), 32'd0);
`endif
    #2 rst = 1'b0;
    next_cycle();

    // Test 1: latency DEPTH=3, then 10 back-to-back beats.
    for (int c = 0; c < 15; c++) begin
      a_in_valid  = (c < 10);
      a_in_data   = 32'(c + 1);
      a_out_ready = 1'b1;
      @(negedge clk);
      if (c < 10) check("t1_in_ready", 32'(a_in_ready), 32'd1);
      check("t1_out_valid", 32'(a_out_valid), 32'((c >= 3) && (c < 13)));
      if ((c >= 3) && (c < 13)) check("t1_out_data", a_out_data, 32'(c - 2));
      next_cycle();
    end
    a_in_valid = 1'b0;

    // Test 2: table-driven on dut_b.
    for (int i = 0; i < 11; i++) begin
      b_in_valid  = tbl[i].in_valid;
      b_in_data   = tbl[i].in_data;
      b_out_ready = tbl[i].out_ready;
      @(negedge clk);
      $display("[TB] t2 row %0d: in_ready=%0b out_valid=%0b out_data=%08h",
               i, b_in_ready, b_out_valid, b_out_data);
      check("t2_in_ready", 32'(b_in_ready), 32'(tbl[i].exp_in_ready));
      check("t2_out_valid", 32'(b_out_valid), 32'(tbl[i].exp_out_valid));
      if (tbl[i].exp_out_valid) check("t2_out_data", b_out_data, tbl[i].exp_out_data);
`ifdef REG_PIPE_OCC_EN
      check("t2_occ", 32'(b_occ), 32'(tbl[i].exp_occ));
`endif
      next_cycle();
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;

    // Test 3: fill, then toggling out_ready with random in_valid.
    for (int c = 0; c < 8; c++) begin
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = $urandom;
      next_cycle();
    end
    for (int c = 0; c < 200; c++) begin
      a_out_ready = c[0];
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in_data   = $urandom;
      next_cycle();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (12) next_cycle();
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Test 4: hold for 5 cycles mid-stream.
    for (int c = 0; c < 6; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h400 + 32'(c);
      next_cycle();
    end
    hold = 1'b1;
    a_in_data = 32'h406;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        held_data = a_out_data;
`ifdef REG_PIPE_OCC_EN
        held_occ = int'(a_occ);
`else
        held_occ = 0;
`endif
      end else begin
        check("t4_data_frozen", a_out_data, held_data);
`ifdef REG_PIPE_OCC_EN
        check("t4_occ_frozen", 32'(a_occ), 32'(held_occ));
`endif
      end
      check("t4_in_ready", 32'(a_in_ready), 32'd0);
      check("t4_out_valid", 32'(a_out_valid), 32'd0);
      next_cycle();
    end
    hold = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a_in_data = 32'h406 + 32'(c);
      @(negedge clk);
      if (c == 0) check("t4_resume_ready", 32'(a_in_ready), 32'd1);
      next_cycle();
    end
    a_in_valid = 1'b0;
    repeat (10) next_cycle();
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Test 5: clear with 3 beats in flight and a beat offered.
    a_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h501 + 32'(c);
      next_cycle();
    end
    clear = 1'b1;
    a_in_data = 32'hDEAD;
    @(negedge clk);
    check("t5_clear_handshake", 32'(a_in_ready), 32'd1);
    next_cycle();
    clear = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    check("t5_out_valid", 32'(a_out_valid), 32'd0);
    check("t5_out_data", a_out_data, 32'd0);
`ifdef REG_PIPE_OCC_EN
    check("t5_occ", 32'(a_occ), 32'd0);
`endif
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      @(negedge clk);
      check("t5_no_ghost", 32'(a_out_valid), 32'd0);
    end
    next_cycle();

    // Test 6: asynchronous reset mid-cycle while full.
    a_out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h600 + 32'(c);
      next_cycle();
    end
    a_in_valid = 1'b0;
    check("t6_pre_full", 32'(a_in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("t6_rst_out_data", a_out_data, 32'd0);
    check("t6_rst_in_ready", 32'(a_in_ready), 32'd0);
`ifdef REG_PIPE_OCC_EN
    check("t6_rst_occ", 32'(a_occ), 32'd0);
`endif
    @(negedge clk);
    #2 rst = 1'b0;
    next_cycle();
    a_in_valid = 1'b1; a_in_data = 32'h6A5; a_out_ready = 1'b1;
    @(negedge clk);
    check("t6_accept_after_rst", 32'(a_in_ready), 32'd1);
    next_cycle();
    a_in_valid = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("t6_out_valid", 32'(a_out_valid), 32'd1);
    check("t6_out_data", a_out_data, 32'h6A5);
    next_cycle();
    repeat (4) next_cycle();
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
